// File: rtl/snail_pkg.sv
// Shared helpers for the snail sequence detector: width math and the idle state value.
package snail_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

   // match_len must encode 0..pat_w inclusive
   function automatic int unsigned state_w(input int unsigned pat_w);
      return clog2(pat_w + 1);
   endfunction

   localparam int unsigned MATCH_IDLE = 0;

endpackage

// File: rtl/snail_prefix_match.sv
// Combinational longest suffix-equals-prefix search over recent history plus the new bit.
module snail_prefix_match
   import snail_pkg::*;
#(
   parameter int unsigned  PAT_W = 3,
   localparam int unsigned SW    = state_w(PAT_W)
) (
   input  logic [PAT_W-2:0] hist_i,
   input  logic             d_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [SW-1:0]    cur_len_i,
   output logic [SW-1:0]    next_len_o
);

   logic [PAT_W-1:0] win;
   logic [PAT_W-1:0] mask;
   logic [PAT_W-1:0] pfx;

   // A match can grow by at most one bit, so k is capped at cur_len_i+1; this also keeps
   // history bits that were never really received (after reset or load) out of the search.
   always_comb begin
      win        = {hist_i, d_i};
      mask       = '0;
      pfx        = '0;
      next_len_o = '0;
      for (int unsigned k = 1; k <= PAT_W; k++) begin
         mask = {PAT_W{1'b1}} >> (PAT_W - k);
         pfx  = pattern_i >> (PAT_W - k);
         if ((k <= 32'(cur_len_i) + 32'd1) && (((win ^ pfx) & mask) == '0)) begin
            next_len_o = SW'(k);
         end
      end
   end

endmodule

// File: rtl/snail_seq_detector.sv
// Serial pattern detector with run-time loadable pattern and Moore match flag Q.
// Define SNAIL_HITCNT_EN to add the saturating hit_cnt output.
module snail_seq_detector
   import snail_pkg::*;
#(
   parameter int unsigned      PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b101,
   parameter bit               OVERLAP = 1'b1,
`ifdef SNAIL_HITCNT_EN
   parameter int unsigned      CNT_W   = 8,
`endif
   localparam int unsigned     SW      = state_w(PAT_W)
) (
   input  logic             clk,
   input  logic             _rst,
   input  logic             D,
   input  logic             en,
   input  logic             pat_ld,
   input  logic [PAT_W-1:0] pat_in,
   output logic             Q,
`ifdef SNAIL_HITCNT_EN
   output logic [CNT_W-1:0] hit_cnt,
`endif
   output logic [SW-1:0]    match_len
);

   localparam logic [SW-1:0] LenFull = SW'(PAT_W);
   localparam logic [SW-1:0] LenIdle = SW'(MATCH_IDLE);

   logic [SW-1:0]    len_q, len_d, cur_len, next_len;
   logic [PAT_W-2:0] hist_q, hist_d;
   logic [PAT_W-1:0] pat_q, pat_d;

   // Non-overlapping mode forgets everything once a full match has been reported.
   always_comb begin
      cur_len = (!OVERLAP && (len_q == LenFull)) ? LenIdle : len_q;
   end

   snail_prefix_match #(
      .PAT_W(PAT_W)
   ) u_prefix (
      .hist_i    (hist_q),
      .d_i       (D),
      .pattern_i (pat_q),
      .cur_len_i (cur_len),
      .next_len_o(next_len)
   );

   always_comb begin
      len_d  = len_q;
      hist_d = hist_q;
      pat_d  = pat_q;
      if (pat_ld) begin
         pat_d  = pat_in;
         len_d  = LenIdle;
         hist_d = '0;
      end else if (en) begin
         len_d  = next_len;
         hist_d = (PAT_W-1)'({hist_q, D});
      end
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         len_q  <= LenIdle;
         hist_q <= '0;
         pat_q  <= PATTERN;
      end else begin
         len_q  <= len_d;
         hist_q <= hist_d;
         pat_q  <= pat_d;
      end
   end

   assign Q         = (len_q == LenFull);
   assign match_len = len_q;

`ifdef SNAIL_HITCNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (pat_ld) begin
         cnt_d = '0;
      end else if (en && (next_len == LenFull) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_snail_seq_detector.sv
// Bench for snail_seq_detector: overlapping and non-overlapping instances against a
// queue-based model of "longest recent suffix equal to a pattern prefix".
module tb_snail_seq_detector;

   localparam int W    = 3;
   localparam int CMAX = 3;

   logic       clk;
   logic       rst_n;
   logic       D;
   logic       en;
   logic       pat_ld;
   logic [2:0] pat_in;
   logic       ov_q, no_q;
   logic [1:0] ov_len, no_len;
`ifdef SNAIL_HITCNT_EN
   logic [1:0] ov_cnt, no_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_on   = 0;

   // Model state: received bits since the last restart, pattern, lengths, hit counts.
   bit         q0[$];
   bit         q1[$];
   logic [2:0] m_pat;
   int         len0, len1, cnt0, cnt1;

   int p_ov, p_no;
   bit s_t1[5]   = '{1, 0, 1, 0, 1};
   int e_t1ov[5] = '{1, 2, 3, 2, 3};
   int e_t1no[5] = '{1, 2, 3, 0, 1};
   bit s_t3[6]   = '{1, 1, 0, 1, 1, 0};
   int e_t3[6]   = '{1, 2, 3, 1, 2, 3};
   int e_t6ov[4] = '{1, 2, 3, 3};
   int e_t6no[4] = '{1, 2, 3, 1};
   int e_cnt[5]  = '{1, 2, 3, 3, 3};

   snail_seq_detector #(
      .PAT_W  (3),
      .PATTERN(3'b101),
`ifdef SNAIL_HITCNT_EN
      .CNT_W  (2),
`endif
      .OVERLAP(1'b1)
   ) u_ov (
      .clk      (clk),
      ._rst     (rst_n),
      .D        (D),
      .en       (en),
      .pat_ld   (pat_ld),
      .pat_in   (pat_in),
      .Q        (ov_q),
`ifdef SNAIL_HITCNT_EN
      .hit_cnt  (ov_cnt),
`endif
      .match_len(ov_len)
   );

   snail_seq_detector #(
      .PAT_W  (3),
      .PATTERN(3'b101),
`ifdef SNAIL_HITCNT_EN
      .CNT_W  (2),
`endif
      .OVERLAP(1'b0)
   ) u_no (
      .clk      (clk),
      ._rst     (rst_n),
      .D        (D),
      .en       (en),
      .pat_ld   (pat_ld),
      .pat_in   (pat_in),
      .Q        (no_q),
`ifdef SNAIL_HITCNT_EN
      .hit_cnt  (no_cnt),
`endif
      .match_len(no_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int longest(input bit qq[$], input logic [2:0] pat);
      int n    = qq.size();
      int best = 0;
      bit ok;
      for (int k = 1; k <= W; k++) begin
         if (k <= n) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
               if (qq[n-k+i] != pat[W-1-i]) ok = 1'b0;
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      m_pat = 3'b101;
      len0  = 0;
      len1  = 0;
      cnt0  = 0;
      cnt1  = 0;
   endtask

   task automatic model_edge(input bit d, input bit e, input bit ld, input logic [2:0] pi);
      if (ld) begin
         q0.delete();
         q1.delete();
         m_pat = pi;
         len0  = 0;
         len1  = 0;
         cnt0  = 0;
         cnt1  = 0;
      end else if (e) begin
         if (len1 == W) q1.delete();
         q0.push_back(d);
         q1.push_back(d);
         while (q0.size() > W) void'(q0.pop_front());
         while (q1.size() > W) void'(q1.pop_front());
         len0 = longest(q0, m_pat);
         len1 = longest(q1, m_pat);
         if (len0 == W && cnt0 < CMAX) cnt0++;
         if (len1 == W && cnt1 < CMAX) cnt1++;
      end
   endtask

   task automatic step(input bit d, input bit e, input bit ld, input logic [2:0] pi);
      D      = d;
      en     = e;
      pat_ld = ld;
      pat_in = pi;
      @(posedge clk);
      model_edge(d, e, ld, pi);
      #1;
   endtask

   // Single compare process: every falling edge, both instances against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("ov.match_len", int'(ov_len), len0);
         chk("ov.Q", int'(ov_q), (len0 == W) ? 1 : 0);
         chk("no.match_len", int'(no_len), len1);
         chk("no.Q", int'(no_q), (len1 == W) ? 1 : 0);
`ifdef SNAIL_HITCNT_EN
         chk("ov.hit_cnt", int'(ov_cnt), cnt0);
         chk("no.hit_cnt", int'(no_cnt), cnt1);
`endif
      end
   end

   initial begin
      rst_n  = 1'b0;
      D      = 1'b0;
      en     = 1'b0;
      pat_ld = 1'b0;
      pat_in = 3'b000;
      model_reset();
      #1;
      chk("reset.ov_len", int'(ov_len), 0);
      chk("reset.ov_q", int'(ov_q), 0);
      chk("reset.no_len", int'(no_len), 0);
      chk("reset.no_q", int'(no_q), 0);
      chk_on = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Default 101, stream 1,0,1,0,1.
      p_ov = 0;
      p_no = 0;
      for (int i = 0; i < 5; i++) begin
         step(s_t1[i], 1'b1, 1'b0, 3'b000);
         chk("t1.ov_len", int'(ov_len), e_t1ov[i]);
         chk("t1.no_len", int'(no_len), e_t1no[i]);
         p_ov += int'(ov_q);
         p_no += int'(no_q);
      end
      chk("t1.ov_pulses", p_ov, 2);
      chk("t1.no_pulses", p_no, 1);

      // Load 110; D on the load edge is ignored.
      step(1'b1, 1'b1, 1'b1, 3'b110);
      chk("t3.load_len", int'(ov_len), 0);
      chk("t3.load_q", int'(ov_q), 0);
      for (int i = 0; i < 6; i++) begin
         step(s_t3[i], 1'b1, 1'b0, 3'b000);
         chk("t3.ov_len", int'(ov_len), e_t3[i]);
         chk("t3.no_len", int'(no_len), e_t3[i]);
      end

      // Hold with en=0 while D toggles.
      step(1'b0, 1'b1, 1'b1, 3'b101);
      step(1'b1, 1'b1, 1'b0, 3'b000);
      step(1'b0, 1'b1, 1'b0, 3'b000);
      for (int i = 0; i < 4; i++) begin
         step(i[0], 1'b0, 1'b0, 3'b000);
         chk("t4.hold_len", int'(ov_len), 2);
         chk("t4.hold_q", int'(ov_q), 0);
      end
      step(1'b1, 1'b1, 1'b0, 3'b000);
      chk("t4.resume_q", int'(ov_q), 1);

      // Asynchronous reset between edges with match_len=2.
      step(1'b0, 1'b1, 1'b1, 3'b101);
      step(1'b1, 1'b1, 1'b0, 3'b000);
      step(1'b0, 1'b1, 1'b0, 3'b000);
      chk("t5.pre_len", int'(ov_len), 2);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5.async_len", int'(ov_len), 0);
      chk("t5.async_q", int'(ov_q), 0);
      chk("t5.async_no_len", int'(no_len), 0);
      #1 rst_n = 1'b1;
      step(1'b0, 1'b1, 1'b0, 3'b000);
      chk("t5.post0_len", int'(ov_len), 0);
      step(1'b1, 1'b1, 1'b0, 3'b000);
      chk("t5.post1_len", int'(ov_len), 1);
      chk("t5.post1_q", int'(ov_q), 0);

      // Degenerate all-ones pattern.
      step(1'b0, 1'b1, 1'b1, 3'b111);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 3'b000);
         chk("t6.ov_len", int'(ov_len), e_t6ov[i]);
         chk("t6.no_len", int'(no_len), e_t6no[i]);
      end

      // Five overlapping 101 matches, then clear by load.
      step(1'b0, 1'b1, 1'b1, 3'b101);
      for (int i = 0; i < 11; i++) begin
         step(~i[0], 1'b1, 1'b0, 3'b000);
`ifdef SNAIL_HITCNT_EN
         if (i >= 2 && i[0] == 1'b0) chk("t7.ov_cnt", int'(ov_cnt), e_cnt[(i-2)/2]);
`endif
      end
      step(1'b0, 1'b1, 1'b1, 3'b101);
`ifdef SNAIL_HITCNT_EN
      chk("t7.cnt_clear", int'(ov_cnt), 0);
`endif

      // Randomised traffic, including occasional pattern loads.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)));
      end

      en     = 1'b0;
      pat_ld = 1'b0;
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
